minv_mdiv_seq: RTL and testbench

Command sequencer for the 256-bit modular inverse / modular division engine. It accepts one command from a bus-side requester and streams the operand words into the engine with the per-operand load strobes. It then launches the operation, waits for completion, and drains the 256-bit result back to the requester as eight 32-bit words over a valid/ready stream. It sits between the core's accelerator interface and the engine, and is the engine's only driver.

---
 rtl/minv_mdiv_seq.sv | 212 +++++++++++++++++++++
 tb/tb_minv_mdiv_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minv_mdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : minv_mdiv_seq
// Purpose  : Command sequencer for the 256-bit modular inverse / modular
//            division engine. Accepts one command, streams the operand words
//            into the engine with the per-operand load strobes, launches the
//            operation, waits for completion (with optional timeout) and
//            drains the result words back over a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous reset, active low
//   cmd_valid     in   1   command request
//   cmd_ready     out  1   command accepted (high only when idle)
//   cmd_inv       in   1   1 = inverse (p, a), 0 = division (p, a, b)
//   cmd_keep_p    in   1   1 = reuse the engine's resident p
//   in_valid      in   1   operand word valid
//   in_ready      out  1   operand word accepted
//   in_data       in   32  operand word, least-significant word first
//   res_valid     out  1   result word valid
//   res_ready     in   1   result consumer ready
//   res_data      out  32  result word, least-significant word first
//   res_last      out  1   marks the final result word
//   busy          out  1   sequencer not idle
//   err_timeout   out  1   sticky timeout flag, cleared by the next command
//   mm_datain     out  32  engine data input
//   mm_loadp/a/b  out  1   engine load strobes, one word per high cycle
//   mm_minv_mdiv  out  1   engine operation select
//   mm_en         out  1   engine start pulse
//   mm_rdy        in   1   engine completion level
//   mm_out_valid  in   1   engine result word valid
//   mm_out_ready  out  1   engine result word taken
//   mm_result     in   32  engine result word
// ============================================================================
module minv_mdiv_seq #(
   parameter int WORDS     = 8,
   parameter int TO_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_inv,
   input  logic        cmd_keep_p,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_last,
   output logic        busy,
   output logic        err_timeout,
   output logic [31:0] mm_datain,
   output logic        mm_loadp,
   output logic        mm_loada,
   output logic        mm_loadb,
   output logic        mm_minv_mdiv,
   output logic        mm_en,
   input  logic        mm_rdy,
   input  logic        mm_out_valid,
   output logic        mm_out_ready,
   input  logic [31:0] mm_result
);

   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;

   localparam logic [CW-1:0] C_LAST_WORD = CW'(WORDS - 1);
   localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
   localparam logic [TW-1:0] C_TO_ONE    = TW'(1);
   // Value held by the wait counter on the last permitted WAIT cycle.
   localparam logic [TW-1:0] C_TO_LAST   = (TO_CYCLES > 0) ? TW'(TO_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_P = 3'd1,
      S_LOAD_A = 3'd2,
      S_LOAD_B = 3'd3,
      S_START  = 3'd4,
      S_WAIT   = 3'd5,
      S_DRAIN  = 3'd6
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [TW-1:0] r_to_cnt;
   logic [TW-1:0] w_to_nxt;
   logic          r_op_inv;
   logic          w_op_nxt;
   logic          r_err;
   logic          w_err_nxt;

   logic          w_loading;
   logic          w_last_word;
   logic          w_res_hs;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_to_cnt <= '0;
         r_op_inv <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_to_cnt <= w_to_nxt;
         r_op_inv <= w_op_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign w_loading   = (r_state == S_LOAD_P) || (r_state == S_LOAD_A) ||
                        (r_state == S_LOAD_B);
   assign w_last_word = (r_cnt == C_LAST_WORD);
   // The drain handshake is counted on the engine side of the pass-through.
   assign w_res_hs    = mm_out_valid && res_ready;

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_to_nxt     = r_to_cnt;
      w_op_nxt     = r_op_inv;
      w_err_nxt    = r_err;

      cmd_ready    = (r_state == S_IDLE);
      busy         = (r_state != S_IDLE);
      in_ready     = w_loading;
      mm_datain    = w_loading ? in_data : 32'h0;
      mm_loadp     = (r_state == S_LOAD_P) && in_valid;
      mm_loada     = (r_state == S_LOAD_A) && in_valid;
      mm_loadb     = (r_state == S_LOAD_B) && in_valid;
      mm_en        = (r_state == S_START);
      mm_minv_mdiv = r_op_inv;
      res_valid    = (r_state == S_DRAIN) && mm_out_valid;
      mm_out_ready = (r_state == S_DRAIN) && res_ready;
      res_data     = mm_result;
      res_last     = (r_state == S_DRAIN) && mm_out_valid && w_last_word;
      err_timeout  = r_err;

      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_op_nxt    = cmd_inv;
               w_err_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = cmd_keep_p ? S_LOAD_A : S_LOAD_P;
            end
         end

         S_LOAD_P, S_LOAD_A, S_LOAD_B: begin
            if (in_valid) begin
               if (w_last_word) begin
                  w_cnt_nxt = '0;
                  case (r_state)
                     S_LOAD_P: w_state_nxt = S_LOAD_A;
                     S_LOAD_A: w_state_nxt = r_op_inv ? S_START : S_LOAD_B;
                     default:  w_state_nxt = S_START;
                  endcase
               end else begin
                  w_cnt_nxt = r_cnt + C_CNT_ONE;
               end
            end
         end

         S_START: begin
            w_to_nxt    = '0;
            w_state_nxt = S_WAIT;
         end

         S_WAIT: begin
            w_to_nxt = r_to_cnt + C_TO_ONE;
            // Completion wins over a timeout landing on the same cycle.
            if (mm_rdy) begin
               w_to_nxt    = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_DRAIN;
            end else if ((TO_CYCLES != 0) && (r_to_cnt == C_TO_LAST)) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         S_DRAIN: begin
            if (w_res_hs) begin
               if (w_last_word) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + C_CNT_ONE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_minv_mdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_minv_mdiv_seq
// Purpose  : Self-checking bench for minv_mdiv_seq with a behavioural engine
//            model. Expected result words are derived from the driven
//            operands and queued at command issue; the drain loop pops and
//            compares them as the sequencer delivers them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : none (top-level bench)
// ============================================================================
module tb_minv_mdiv_seq;

   localparam int WORDS  = 8;
   localparam int TO_CYC = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_inv = 1'b0;
   logic        cmd_keep_p = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_last;
   logic        busy;
   logic        err_timeout;
   logic [31:0] mm_datain;
   logic        mm_loadp;
   logic        mm_loada;
   logic        mm_loadb;
   logic        mm_minv_mdiv;
   logic        mm_en;
   logic        mm_rdy;
   logic        mm_out_valid;
   logic        mm_out_ready;
   logic [31:0] mm_result;

   always #5 clk = ~clk;

   minv_mdiv_seq #(.WORDS(WORDS), .TO_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inv(cmd_inv),
      .cmd_keep_p(cmd_keep_p),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .busy(busy), .err_timeout(err_timeout),
      .mm_datain(mm_datain), .mm_loadp(mm_loadp), .mm_loada(mm_loada),
      .mm_loadb(mm_loadb), .mm_minv_mdiv(mm_minv_mdiv), .mm_en(mm_en),
      .mm_rdy(mm_rdy), .mm_out_valid(mm_out_valid),
      .mm_out_ready(mm_out_ready), .mm_result(mm_result)
   );

   // ------------------------------------------------------------------------
   // Behavioural engine: captures strobed words, raises mm_rdy cfg_delay+1
   // cycles after mm_en (never when cfg_delay is 255), then offers 8 words.
   // ------------------------------------------------------------------------
   int          cfg_delay = 0;
   logic [31:0] ep [8];
   logic [31:0] ea [8];
   logic [31:0] eb [8];
   logic [2:0]  e_pi = 3'd0, e_ai = 3'd0, e_bi = 3'd0, e_oi = 3'd0;
   logic        e_rdy = 1'b0, e_pend = 1'b0, e_op = 1'b0;
   int          e_dly = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_pi <= 3'd0; e_ai <= 3'd0; e_bi <= 3'd0; e_oi <= 3'd0;
         e_rdy <= 1'b0; e_pend <= 1'b0; e_op <= 1'b0; e_dly <= 0;
      end else begin
         if (mm_loadp) begin ep[e_pi] <= mm_datain; e_pi <= e_pi + 3'd1; end
         if (mm_loada) begin ea[e_ai] <= mm_datain; e_ai <= e_ai + 3'd1; end
         if (mm_loadb) begin eb[e_bi] <= mm_datain; e_bi <= e_bi + 3'd1; end
         if (mm_en) begin
            e_pend <= 1'b1; e_dly <= cfg_delay; e_op <= mm_minv_mdiv;
            e_oi <= 3'd0; e_pi <= 3'd0; e_ai <= 3'd0; e_bi <= 3'd0;
         end else if (e_pend && cfg_delay != 255) begin
            if (e_dly == 0) begin e_rdy <= 1'b1; e_pend <= 1'b0; end
            else e_dly <= e_dly - 1;
         end
         if (e_rdy && mm_out_ready) begin
            if (e_oi == 3'd7) begin e_rdy <= 1'b0; e_oi <= 3'd0; end
            else e_oi <= e_oi + 3'd1;
         end
      end
   end

   assign mm_rdy       = e_rdy;
   assign mm_out_valid = e_rdy;
   assign mm_result    = (ep[e_oi] + ea[e_oi]) ^ (e_op ? 32'hA5A5_0000 : eb[e_oi]);

   // ------------------------------------------------------------------------
   // Strobe monitor: running totals only, sampled mid-cycle
   // ------------------------------------------------------------------------
   int   np_tot = 0, na_tot = 0, nb_tot = 0, nen_tot = 0, rv_tot = 0;
   int   din_bad = 0, multi_bad = 0, op_bad = 0;
   logic exp_op = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         if (mm_loadp) np_tot++;
         if (mm_loada) na_tot++;
         if (mm_loadb) nb_tot++;
         if ((mm_loadp || mm_loada || mm_loadb) && mm_datain !== in_data) din_bad++;
         if (int'(mm_loadp) + int'(mm_loada) + int'(mm_loadb) > 1) multi_bad++;
         if (mm_en) nen_tot++;
         if (res_valid) rv_tot++;
         if (busy && mm_minv_mdiv !== exp_op) op_bad++;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus, scoreboard and checks
   // ------------------------------------------------------------------------
   typedef struct {
      logic inv;
      logic keep;
      logic gap;
      logic bp;
      int   delay;
      int   np;
      int   na;
      int   nb;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] wp [8];
   logic [31:0] wa [8];
   logic [31:0] wb [8];
   logic [31:0] res_p [8];
   logic [31:0] q [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] model(input logic [31:0] p, input logic [31:0] a,
                                         input logic [31:0] b, input logic inv);
      return (p + a) ^ (inv ? 32'hA5A5_0000 : b);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: actual=bound expired required=event", name);
   endtask

   task automatic gen_words();
      for (int i = 0; i < 8; i++) begin
         wp[i] = $urandom; wa[i] = $urandom; wb[i] = $urandom;
      end
   endtask

   task automatic issue_cmd(input logic inv, input logic keep, input logic push);
      int n;
      n = 0;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!cmd_ready) fail_now("cmd_ready_wait");
      if (!keep) for (int i = 0; i < 8; i++) res_p[i] = wp[i];
      if (push) for (int i = 0; i < 8; i++) q.push_back(model(res_p[i], wa[i], wb[i], inv));
      exp_op     = inv;
      cmd_inv    = inv;
      cmd_keep_p = keep;
      cmd_valid  = 1'b1;
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      cmd_inv    = ~inv;
      cmd_keep_p = ~keep;
   endtask

   task automatic feed_words(input int sel, input int n, input logic gap);
      logic tog;
      tog = 1'b0;
      for (int w = 0; w < n; w++) begin
         int   guard;
         logic hs;
         guard = 0;
         hs    = 1'b0;
         do begin
            in_data  = (sel == 0) ? wp[w] : (sel == 1) ? wa[w] : wb[w];
            in_valid = gap ? tog : 1'b1;
            tog      = ~tog;
            hs       = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
         end while (!hs && guard < 64);
         if (!hs) fail_now("feed_wait");
      end
      in_valid = 1'b0;
   endtask

   task automatic feed_all(input logic inv, input logic keep, input logic gap);
      if (!keep) feed_words(0, 8, gap);
      feed_words(1, 8, gap);
      if (!inv) feed_words(2, 8, gap);
   endtask

   task automatic drain(input logic bp);
      int          got, bp_left, guard;
      logic [31:0] exp;
      got = 0; bp_left = 3; guard = 0;
      while (got < 8 && guard < 200) begin
         res_ready = (bp && got == 3 && bp_left > 0) ? 1'b0 : 1'b1;
         if (!res_ready) bp_left--;
         @(negedge clk);
         if (!res_ready) begin
            chk("bp_mm_out_ready", {31'b0, mm_out_ready}, 32'd0);
            chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
         end
         if (res_valid && res_ready) begin
            if (q.size() == 0) begin
               fail_now("scoreboard_empty");
            end else begin
               exp = q.pop_front();
               chk($sformatf("res_data_w%0d", got), res_data, exp);
               chk($sformatf("res_last_w%0d", got), {31'b0, res_last}, {31'b0, (got == 7)});
            end
            got++;
         end
         @(posedge clk); #1;
         guard++;
      end
      if (got < 8) fail_now("drain_wait");
      res_ready = 1'b0;
      chk("b2b_cmd_ready", {31'b0, cmd_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int s_p, s_a, s_b, s_en, s_din, s_multi, s_op;
      gen_words();
      cfg_delay = v.delay;
      s_p = np_tot; s_a = na_tot; s_b = nb_tot; s_en = nen_tot;
      s_din = din_bad; s_multi = multi_bad; s_op = op_bad;
      issue_cmd(v.inv, v.keep, 1'b1);
      feed_all(v.inv, v.keep, v.gap);
      drain(v.bp);
      chk($sformatf("v%0d_loadp_cnt", idx), np_tot - s_p, v.np);
      chk($sformatf("v%0d_loada_cnt", idx), na_tot - s_a, v.na);
      chk($sformatf("v%0d_loadb_cnt", idx), nb_tot - s_b, v.nb);
      chk($sformatf("v%0d_mm_en_cnt", idx), nen_tot - s_en, 1);
      chk($sformatf("v%0d_datain", idx), din_bad - s_din, 0);
      chk($sformatf("v%0d_one_strobe", idx), multi_bad - s_multi, 0);
      chk($sformatf("v%0d_op_select", idx), op_bad - s_op, 0);
      chk($sformatf("v%0d_queue_empty", idx), q.size(), 0);
      chk($sformatf("v%0d_err", idx), {31'b0, err_timeout}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, k, s_rv, s_op;
      vec_t fresh;
      logic [3:0] exp4;

      //           inv   keep  gap   bp    dly np na nb
      vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 8, 8, 8};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 8, 0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 8, 8, 8};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 0, 8, 8};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5, 8, 8, 0};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 8, 8, 0};  // mm_rdy on the timeout cycle

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outs", {cmd_ready, busy, in_ready, mm_loadp, mm_loada, mm_loadb, mm_en,
                         mm_minv_mdiv, res_valid, res_last, mm_out_ready, err_timeout}, 12'h800);
      chk("reset_datain", mm_datain, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_outs", {cmd_ready, busy, in_ready, mm_loadp, mm_loada, mm_loadb, mm_en,
                              mm_minv_mdiv, res_valid, res_last, mm_out_ready, err_timeout}, 12'h800);
      @(posedge clk); #1;

      // Inverse with continuous operand stream: exact strobe timing
      for (int i = 0; i < 8; i++) begin
         wp[i] = 32'h1 + i;
         wa[i] = 32'h11 + i;
      end
      cfg_delay = 2;
      s_op = op_bad;
      issue_cmd(1'b1, 1'b0, 1'b1);
      for (int rel = 1; rel <= 17; rel++) begin
         in_valid = (rel <= 16);
         if (rel <= 8)       in_data = wp[rel-1];
         else if (rel <= 16) in_data = wa[rel-9];
         else                in_data = 32'h0;
         @(negedge clk);
         exp4 = {(rel <= 8), (rel > 8 && rel <= 16), 1'b0, (rel == 17)};
         chk($sformatf("t1_strobes_c%0d", rel), {28'b0, mm_loadp, mm_loada, mm_loadb, mm_en},
             {28'b0, exp4});
         if (rel <= 16)
            chk($sformatf("t1_datain_c%0d", rel), mm_datain, in_data);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain(1'b0);
      chk("t1_op_select", op_bad - s_op, 0);

      // Table-driven command mix
      for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

      // Timeout: engine never completes
      gen_words();
      cfg_delay = 255;
      s_rv = rv_tot;
      issue_cmd(1'b1, 1'b0, 1'b0);
      feed_all(1'b1, 1'b0, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!mm_en && n < 50);
      if (!mm_en) fail_now("to_mm_en_wait");
      k = 0;
      do begin @(negedge clk); k++; end while (!cmd_ready && k < 40);
      chk("to_idle_cycles", k, 11);
      chk("to_err_set", {31'b0, err_timeout}, 32'd1);
      chk("to_no_res_valid", rv_tot - s_rv, 0);
      @(posedge clk); #1;
      gen_words();
      cfg_delay = 1;
      issue_cmd(1'b0, 1'b0, 1'b1);
      chk("to_err_cleared", {31'b0, err_timeout}, 32'd0);
      feed_all(1'b0, 1'b0, 1'b0);
      drain(1'b0);

      // Reset asserted mid LOAD_A
      gen_words();
      cfg_delay = 1;
      issue_cmd(1'b1, 1'b0, 1'b0);
      feed_words(0, 8, 1'b0);
      feed_words(1, 3, 1'b0);
      in_valid = 1'b1;
      in_data  = wa[3];
      #1;
      chk("pre_rst_loada", {31'b0, mm_loada}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_outs", {cmd_ready, busy, in_ready, mm_loadp, mm_loada, mm_loadb, mm_en,
                           mm_minv_mdiv, res_valid, res_last, mm_out_ready, err_timeout}, 12'h800);
      chk("mid_rst_datain", mm_datain, 32'h0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      fresh = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 8, 8, 0};
      run_vec(fresh, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
